// File: rtl/hex_counter_pkg.sv
// hex_counter_pkg
// Shared definitions for the hex counter source: FSM state type, speed
// select encodings and the rate divider width helper.
package hex_counter_pkg;

   typedef enum logic {
      STOPPED = 1'b0,
      RUNNING = 1'b1
   } state_t;

   localparam logic [1:0] SPEED_X1 = 2'b00;
   localparam logic [1:0] SPEED_P1 = 2'b01;
   localparam logic [1:0] SPEED_P2 = 2'b10;
   localparam logic [1:0] SPEED_P3 = 2'b11;

   // Bits needed to hold P-1 for the longest of the three periods.
   function automatic int div_width(input int p1, input int p2, input int p3);
      int m;
      m = p1;
      if (p2 > m) m = p2;
      if (p3 > m) m = p3;
      if (m < 2) return 1;
      return $clog2(m);
   endfunction

endpackage

// File: rtl/rate_divider.sv
// rate_divider
// Down-counter that paces the hex counter. The count is loaded with P-1 on
// reload and walks down to zero while enabled; zero flags terminal count.
// Ports:
//   clk       rising-edge clock
//   reset     asynchronous active-high reset, clears the count
//   enable    decrement permitted (counter holds when low)
//   reload    load period_m1 on the next edge (wins over decrement)
//   period_m1 reload value, P-1
//   zero      count is at terminal value 0
module rate_divider #(
   parameter int W = 26
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         enable,
   input  logic         reload,
   input  logic [W-1:0] period_m1,
   output logic         zero
);

   logic [W-1:0] count;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count <= '0;
      end else if (reload) begin
         count <= period_m1;
      end else if (enable && (count != '0)) begin
         count <= count - W'(1);
      end
   end

   assign zero = (count == '0);

endmodule

// File: rtl/hex_counter_source.sv
// hex_counter_source
// Start/stop controlled hex digit counter with selectable step rate, used to
// drive a 7-segment decoder.
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-high reset
//   start      request RUNNING (stop wins when both high)
//   stop       request STOPPED
//   load       parallel load of load_value into digit (highest priority)
//   load_value value captured by load
//   up         1 = count up, 0 = count down
//   speed      period select: 00 = 1, 01 = TICK_P1, 10 = TICK_P2, 11 = TICK_P3
//   digit      registered hex digit, digit[3] feeds decoder input c3
//   tick       one-cycle pulse in the cycle digit holds a newly counted value
//   wrap       one-cycle pulse with tick when the count wrapped F->0 or 0->F
//   running    FSM is in RUNNING
//
// state   | meaning
// --------+------------------------------------------------------------
// STOPPED | digit and divider hold, no tick/wrap; waits for start
// RUNNING | divider counts down, digit steps on each terminal count
module hex_counter_source
   import hex_counter_pkg::*;
#(
   parameter int unsigned TICK_P1 = 50_000_000,
   parameter int unsigned TICK_P2 = 25_000_000,
   parameter int unsigned TICK_P3 = 12_500_000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic       stop,
   input  logic       load,
   input  logic [3:0] load_value,
   input  logic       up,
   input  logic [1:0] speed,
   output logic [3:0] digit,
   output logic       tick,
   output logic       wrap,
   output logic       running
);

   localparam int DIV_W = div_width(int'(TICK_P1), int'(TICK_P2), int'(TICK_P3));

   state_t             state;
   state_t             state_nxt;
   logic [1:0]         speed_q;
   logic [DIV_W-1:0]   period_m1;
   logic               div_zero;
   logic               div_reload;
   logic               start_acc;
   logic               speed_chg;
   logic               count_step;
   logic [3:0]         digit_nxt;
   logic               wrap_nxt;

   always_comb begin
      period_m1 = '0;
      case (speed)
         SPEED_X1: period_m1 = '0;
         SPEED_P1: period_m1 = DIV_W'(TICK_P1 - 1);
         SPEED_P2: period_m1 = DIV_W'(TICK_P2 - 1);
         SPEED_P3: period_m1 = DIV_W'(TICK_P3 - 1);
         default:  period_m1 = '0;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= STOPPED;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt  = state;
      start_acc  = 1'b0;
      speed_chg  = (speed != speed_q);
      count_step = 1'b0;
      div_reload = 1'b0;
      if (stop) begin
         state_nxt = STOPPED;
      end else if (start) begin
         state_nxt = RUNNING;
      end
      case (state)
         STOPPED: begin
            start_acc  = start && !stop;
            div_reload = load || start_acc;
         end
         RUNNING: begin
            // A pending speed change or load restarts the period instead of
            // stepping, so neither produces a tick on that edge.
            count_step = div_zero && !load && !speed_chg;
            div_reload = load || speed_chg || div_zero;
         end
         default: begin
            state_nxt = STOPPED;
         end
      endcase
   end

   always_comb begin
      digit_nxt = up ? (digit + 4'd1) : (digit - 4'd1);
      wrap_nxt  = up ? (digit == 4'hF) : (digit == 4'h0);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         speed_q <= SPEED_X1;
         digit   <= 4'h0;
         tick    <= 1'b0;
         wrap    <= 1'b0;
      end else begin
         speed_q <= speed;
         tick    <= count_step;
         wrap    <= count_step && wrap_nxt;
         if (load) begin
            digit <= load_value;
         end else if (count_step) begin
            digit <= digit_nxt;
         end
      end
   end

   rate_divider #(
      .W (DIV_W)
   ) u_rate_divider (
      .clk       (clk),
      .reset     (reset),
      .enable    (state == RUNNING),
      .reload    (div_reload),
      .period_m1 (period_m1),
      .zero      (div_zero)
   );

   assign running = (state == RUNNING);

endmodule

// File: tb/tb_hex_counter_source.sv
module tb_hex_counter_source;

   localparam int P1 = 4;
   localparam int P2 = 3;
   localparam int P3 = 2;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       start = 1'b0;
   logic       stop = 1'b0;
   logic       load = 1'b0;
   logic [3:0] load_value = 4'h0;
   logic       up = 1'b1;
   logic [1:0] speed = 2'b00;
   logic [3:0] digit;
   logic       tick;
   logic       wrap;
   logic       running;

   hex_counter_source #(
      .TICK_P1 (P1),
      .TICK_P2 (P2),
      .TICK_P3 (P3)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .stop       (stop),
      .load       (load),
      .load_value (load_value),
      .up         (up),
      .speed      (speed),
      .digit      (digit),
      .tick       (tick),
      .wrap       (wrap),
      .running    (running)
   );

   always #5 clk = ~clk;

   // Number of rising edges so far; read on the falling edge after edge k it equals k.
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [3:0] d;
      logic       w;
      int         c;
   } exp_t;

   exp_t q[$];
   int   n_tests = 0;
   int   n_fail = 0;

   task automatic chk(input string name, input int act, input int exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic expect_tick(input logic [3:0] d, input logic w, input int c);
      exp_t e;
      e.d = d;
      e.w = w;
      e.c = c;
      q.push_back(e);
   endtask

   task automatic cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic pulse_stop();
      stop = 1'b1;
      @(negedge clk);
      stop = 1'b0;
   endtask

   // Monitor: every tick must match the next queued expectation.
   always @(negedge clk) begin
      exp_t e;
      if (tick === 1'b1) begin
         if (q.size() == 0) begin
            chk("unexpected_tick_cycle", cyc, -1);
         end else begin
            e = q.pop_front();
            chk("tick_digit", int'(digit), int'(e.d));
            chk("tick_wrap", int'(wrap), int'(e.w));
            chk("tick_cycle", cyc, e.c);
         end
      end else if (wrap === 1'b1) begin
         chk("wrap_without_tick", int'(wrap), 0);
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int n;

      // Reset state
      #1;
      chk("rst_digit", int'(digit), 0);
      chk("rst_tick", int'(tick), 0);
      chk("rst_wrap", int'(wrap), 0);
      chk("rst_running", int'(running), 0);
      @(negedge clk);
      reset = 1'b0;

      // speed=00 counts every clock, wrap only on F->0
      speed = 2'b00;
      up    = 1'b1;
      n = cyc + 1;
      for (int k = 0; k < 16; k++) expect_tick(4'(k + 1), (k == 15), n + 1 + k);
      pulse_start();
      chk("t1_running", int'(running), 1);
      cycles(15);
      pulse_stop();
      cycles(3);
      chk("t1_stopped", int'(running), 0);
      chk("t1_digit", int'(digit), 0);
      chk("t1_drained", q.size(), 0);

      // speed=01 steps every 4 clocks
      speed = 2'b01;
      n = cyc + 1;
      expect_tick(4'h1, 1'b0, n + 4);
      expect_tick(4'h2, 1'b0, n + 8);
      expect_tick(4'h3, 1'b0, n + 12);
      pulse_start();
      cycles(12);
      pulse_stop();
      cycles(4);
      chk("t2_drained", q.size(), 0);
      chk("t2_digit", int'(digit), 3);

      // load 3, count down every 3 clocks with wrap on 0->F
      load       = 1'b1;
      load_value = 4'h3;
      up         = 1'b0;
      speed      = 2'b10;
      cycles(1);
      load = 1'b0;
      chk("t3_load_digit", int'(digit), 3);
      chk("t3_load_tick", int'(tick), 0);
      n = cyc + 1;
      expect_tick(4'h2, 1'b0, n + 3);
      expect_tick(4'h1, 1'b0, n + 6);
      expect_tick(4'h0, 1'b0, n + 9);
      expect_tick(4'hF, 1'b1, n + 12);
      pulse_start();
      cycles(12);
      pulse_stop();
      cycles(4);
      chk("t3_drained", q.size(), 0);

      // start and stop together while STOPPED: nothing moves
      start = 1'b1;
      stop  = 1'b1;
      cycles(1);
      start = 1'b0;
      stop  = 1'b0;
      for (int k = 0; k < 20; k++) begin
         chk("t4_running", int'(running), 0);
         chk("t4_digit", int'(digit), 15);
         cycles(1);
      end

      // speed 01 -> 11 mid-period restarts the period without a tick
      up    = 1'b1;
      speed = 2'b01;
      n = cyc + 1;
      expect_tick(4'h0, 1'b1, n + 4);
      expect_tick(4'h1, 1'b0, n + 7);
      expect_tick(4'h2, 1'b0, n + 9);
      expect_tick(4'h3, 1'b0, n + 11);
      pulse_start();
      cycles(4);
      speed = 2'b11;
      cycles(7);
      pulse_stop();
      cycles(4);
      chk("t5_drained", q.size(), 0);

      // async reset mid-count with digit=A
      load       = 1'b1;
      load_value = 4'h9;
      speed      = 2'b01;
      cycles(1);
      load = 1'b0;
      n = cyc + 1;
      expect_tick(4'hA, 1'b0, n + 4);
      pulse_start();
      cycles(4);
      chk("t6_pre_digit", int'(digit), 10);
      chk("t6_pre_running", int'(running), 1);
      #2;
      reset = 1'b1;
      #1;
      chk("t6_rst_digit", int'(digit), 0);
      chk("t6_rst_running", int'(running), 0);
      chk("t6_rst_tick", int'(tick), 0);
      @(negedge clk);
      reset = 1'b0;
      cycles(10);
      chk("t6_post_running", int'(running), 0);
      chk("t6_post_digit", int'(digit), 0);
      chk("t6_drained", q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/hex_counter_source.md
HEX_COUNTER_SOURCE -- requirements
Module: hex_counter_source

Interface
REQ-001: Parameter TICK_P1, default 50_000_000; divider period in clocks for speed=01.
REQ-002: Parameter TICK_P2, default 25_000_000; divider period in clocks for speed=10.
REQ-003: Parameter TICK_P3, default 12_500_000; divider period in clocks for speed=11. Speed=00 is fixed at period 1.
REQ-004: clk  input  1  single clock; all state updates on its rising edge.
REQ-005: reset  input  1  asynchronous, active-high reset.
REQ-006: start  input  1  synchronous request to enter RUNNING.
REQ-007: stop  input  1  synchronous request to enter STOPPED.
REQ-008: load  input  1  synchronous parallel load of load_value into digit.
REQ-009: load_value  input  4  value captured by load.
REQ-010: up  input  1  count direction: 1 = increment, 0 = decrement.
REQ-011: speed  input  2  period select: 00 = 1, 01 = TICK_P1, 10 = TICK_P2, 11 = TICK_P3.
REQ-012: digit  output  4  registered hex digit; feeds the 7-segment decoder c3..c0 (digit[3]=c3).
REQ-013: tick  output  1  registered one-cycle pulse, high in the cycle digit takes a counted value.
REQ-014: wrap  output  1  registered one-cycle pulse, high with tick when the count crossed F->0 (up) or 0->F (down).
REQ-015: running  output  1  high while FSM is in RUNNING.

Function
REQ-016: FSM has exactly two states, STOPPED and RUNNING; running = (state == RUNNING).
REQ-017: STOPPED -> RUNNING on the edge sampling start=1 and stop=0; RUNNING -> STOPPED on the edge sampling stop=1.
REQ-018: start and stop both high: stop wins; the state becomes or stays STOPPED.
REQ-019: start while already RUNNING: divider is not reloaded and counting continues unchanged.
REQ-020: Rate divider is a down-counter sized to ceil(log2(max period)) bits; P denotes the period selected by the current speed.
REQ-021: On entering RUNNING, the divider loads P-1.
REQ-022: In RUNNING with divider != 0, the divider decrements by 1 each clock.
REQ-023: In RUNNING with divider == 0, on that edge: divider reloads P-1, digit steps by +1 or -1 (mod 16) per up, and tick=1 in the following cycle.
REQ-024: With start accepted at edge N, digit changes at edges N+P, N+2P, and so on; speed=00 changes digit every clock.
REQ-025: A change in speed, detected against a registered copy of speed, reloads the divider with the new P-1 on the next edge; no tick is generated on that edge.
REQ-026: load=1 has highest priority: digit takes load_value next edge, the divider reloads P-1, no tick or wrap is generated, and the FSM state follows REQ-017/018.
REQ-027: In STOPPED, digit holds, the divider holds, and tick and wrap stay 0.
REQ-028: Wrap-around is modulo 16 with no saturation: up F->0 and down 0->F each assert wrap together with tick.
REQ-029: up may change at any time; it takes effect at the next counting edge.

Reset
REQ-030: reset=1 asynchronously forces state=STOPPED, digit=0, divider=0, tick=0, wrap=0, running=0, and registered speed=00.
REQ-031: reset asserted mid-count discards the divider value; after release, the block stays STOPPED until start.

Structure
REQ-032: A shared package hex_counter_pkg holds the FSM state typedef (STOPPED, RUNNING), the speed encoding constants, and the divider width function.
REQ-033: The rate divider is one sub-module, rate_divider: inputs clk, reset, reload, period_m1; output zero.
REQ-034: hex_counter_source instantiates rate_divider and contains the FSM and the 4-bit counter; digit connects directly to the segment decoder inputs.

Verification (TICK_P1=4, TICK_P2=3, TICK_P3=2)
REQ-035: reset, then start with speed=00, up=1 -> digit 1,2,...,F,0 on consecutive clocks; wrap=1 only with the F->0 tick.
REQ-036: speed=01, start at edge N -> digit increments at N+4, N+8, N+12; tick high exactly those cycles.
REQ-037: load=1, load_value=3, up=0, speed=10, then start -> digit 3,2,1,0,F every 3 clocks; wrap pulses on 0->F.
REQ-038: start and stop pulsed in the same cycle while STOPPED -> running stays 0 and digit unchanged for 20 clocks.
REQ-039: RUNNING at speed=01, switch to 11 mid-period -> no tick on the switch edge; next tick 2 clocks later, then every 2.
REQ-040: reset asserted asynchronously between edges while RUNNING with digit=A -> digit=0 and running=0 immediately; no tick after release until start.
